stream_arb_mux: RTL and testbench

- Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake, built-in arbitration and packet locking.
- Successor to the plain 2:1 data mux. It merges several producer streams (rasteriser, blitter, command fetch) onto one downstream pixel/command bus in the 2D GPU datapath.
- The grant is held for a whole packet, so multi-beat bursts are never interleaved.
- Output is registered, giving a one-cycle latency.

---
 rtl/stream_arb_mux.sv | 142 ++++++++++++++
 tb/tb_stream_arb_mux.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// N-channel registered stream multiplexer with round-robin or fixed-priority
// arbitration. The grant is held for a whole packet so bursts never interleave.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no packet open; grant picked combinationally from in_valid
// S_LOCKED | mid-packet; only r_lock_ch may transfer until its last beat
module stream_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int MODE   = 0,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_lock_ch;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic [CH_W-1:0]   r_out_ch;

    logic [CH_W-1:0]   w_idle_gnt;
    logic [CH_W-1:0]   w_sel;
    logic [CH_W-1:0]   w_sel_next;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_load_en;
    logic              w_xfer;
    int                w_dist;
    int                w_best;

    // Pick the valid channel closest to the search start; in MODE 1 the
    // start is always channel 0, which reduces to lowest-index priority.
    always_comb begin
        w_idle_gnt = (MODE == 0) ? r_rr_ptr : '0;
        w_best     = NUM_CH;
        w_dist     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (MODE == 0) begin
                w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr))
                                               : (i + NUM_CH - int'(r_rr_ptr));
            end else begin
                w_dist = i;
            end
            if (in_valid[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_idle_gnt = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_sel       = (r_state == S_LOCKED) ? r_lock_ch : w_idle_gnt;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel == CH_W'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load_en  = !r_out_valid || out_ready;
    assign w_xfer     = !rst && w_load_en && w_sel_valid;
    assign w_sel_next = (w_sel == CH_W'(NUM_CH - 1)) ? '0 : (w_sel + CH_W'(1));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = !rst && w_load_en && (w_sel == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_lock_ch   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            if (w_load_en) begin
                if (w_xfer) begin
                    r_out_data  <= w_sel_data;
                    r_out_last  <= w_sel_last;
                    r_out_ch    <= w_sel;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_sel_last) begin
                            r_state   <= S_LOCKED;
                            r_lock_ch <= w_sel;
                        end else if (MODE == 0) begin
                            r_rr_ptr <= w_sel_next;
                        end
                    end
                    S_LOCKED: begin
                        if (w_sel_last) begin
                            r_state <= S_IDLE;
                            if (MODE == 0) r_rr_ptr <= w_sel_next;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: a round-robin instance (a) and a fixed-priority
// instance (b), checked every cycle against a packet-level model plus literals.
module tb_stream_arb_mux;
    localparam int W = 32;
    localparam int N = 4;

    typedef logic [32:0] beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a, rst_b;
    logic [N*W-1:0] in_data_a, in_data_b;
    logic [N-1:0]   in_valid_a, in_valid_b, in_last_a, in_last_b;
    logic [N-1:0]   in_ready_a, in_ready_b;
    logic [W-1:0]   out_data_a, out_data_b;
    logic           out_valid_a, out_valid_b, out_last_a, out_last_b;
    logic [1:0]     out_ch_a, out_ch_b;
    logic           out_ready_a, out_ready_b;

    stream_arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(0)) dut_a (
        .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_last(in_last_a), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_last(out_last_a), .out_ch(out_ch_a),
        .out_ready(out_ready_a));

    stream_arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(1)) dut_b (
        .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_last(in_last_b), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_last(out_last_b), .out_ch(out_ch_b),
        .out_ready(out_ready_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Producer queues and observed output beats {last, ch, data}
    beat_t        qa[N][$];
    beat_t        qb[N][$];
    logic [34:0]  loga[$];
    logic [34:0]  logb[$];
    logic [N-1:0] fire_a = '0, fire_b = '0;
    bit           mon_on = 1'b0;

    // Packet-level reference: owner = channel holding an open packet, or -1
    int          m_owner[2] = '{-1, -1};
    int          m_ptr[2]   = '{0, 0};
    int          m_mode[2]  = '{0, 1};
    bit          m_ov[2]    = '{1'b0, 1'b0};
    bit          m_zero[2]  = '{1'b1, 1'b1};
    logic [31:0] m_od[2]    = '{32'h0, 32'h0};
    bit          m_ol[2]    = '{1'b0, 1'b0};
    int          m_oc[2]    = '{0, 0};

    function automatic int pick(input int m, input logic [N-1:0] v);
        int c;
        if (m_owner[m] >= 0) return m_owner[m];
        for (int k = 0; k < N; k++) begin
            c = (m_mode[m] == 0) ? ((m_ptr[m] + k) % N) : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [34:0] bt(input bit last, input int ch, input logic [31:0] dat);
        return {last, 2'(ch), dat};
    endfunction

    function automatic logic [34:0] log_at(input int m, input int idx);
        if (m == 0) return (idx < loga.size()) ? loga[idx] : '1;
        return (idx < logb.size()) ? logb[idx] : '1;
    endfunction

    task automatic mon_inst(input int m, input logic rs, input logic [N*W-1:0] d,
                            input logic [N-1:0] v, input logic [N-1:0] l,
                            input logic [N-1:0] rdy, input logic [31:0] od,
                            input logic ov, input logic ol, input logic [1:0] oc,
                            input logic ordy, output logic [N-1:0] f);
        string p;
        int c;
        bit load;
        p = (m == 0) ? "a" : "b";
        load = !m_ov[m] || ordy;
        c = pick(m, v);
        if (rs) chk({p, ".mon.in_ready_rst"}, 64'(rdy), 64'(0));
        else if (c >= 0) chk({p, ".mon.in_ready"}, 64'(rdy), load ? 64'(1 << c) : 64'(0));
        chk({p, ".mon.out_valid"}, 64'(ov), 64'(m_ov[m]));
        if (m_ov[m] || m_zero[m]) begin
            chk({p, ".mon.out_data"}, 64'(od), 64'(m_od[m]));
            chk({p, ".mon.out_last"}, 64'(ol), 64'(m_ol[m]));
            chk({p, ".mon.out_ch"}, 64'(oc), 64'(m_oc[m]));
        end
        if (ov === 1'b1 && ordy) begin
            if (m == 0) loga.push_back({ol, oc, od});
            else        logb.push_back({ol, oc, od});
        end
        f = v & rdy;
        if (rs) begin
            m_owner[m] = -1; m_ptr[m] = 0; m_ov[m] = 0; m_zero[m] = 1;
            m_od[m] = 0; m_ol[m] = 0; m_oc[m] = 0;
        end else if (load) begin
            if (c >= 0 && v[c]) begin
                m_ov[m] = 1; m_zero[m] = 0;
                m_od[m] = d[c*W +: W]; m_ol[m] = l[c]; m_oc[m] = c;
                if (l[c]) begin
                    m_owner[m] = -1;
                    if (m_mode[m] == 0) m_ptr[m] = (c + 1) % N;
                end else begin
                    m_owner[m] = c;
                end
            end else begin
                m_ov[m] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_inst(0, rst_a, in_data_a, in_valid_a, in_last_a, in_ready_a, out_data_a,
                     out_valid_a, out_last_a, out_ch_a, out_ready_a, fire_a);
            mon_inst(1, rst_b, in_data_b, in_valid_b, in_last_b, in_ready_b, out_data_b,
                     out_valid_b, out_last_b, out_ch_b, out_ready_b, fire_b);
        end
    end

    task automatic drive_all();
        beat_t h;
        for (int c = 0; c < N; c++) begin
            if (fire_a[c] && qa[c].size() > 0) void'(qa[c].pop_front());
            if (fire_b[c] && qb[c].size() > 0) void'(qb[c].pop_front());
            if (qa[c].size() > 0) begin
                h = qa[c][0];
                in_valid_a[c] = 1'b1; in_last_a[c] = h[32]; in_data_a[c*W +: W] = h[31:0];
            end else begin
                in_valid_a[c] = 1'b0; in_last_a[c] = 1'b0; in_data_a[c*W +: W] = '0;
            end
            if (qb[c].size() > 0) begin
                h = qb[c][0];
                in_valid_b[c] = 1'b1; in_last_b[c] = h[32]; in_data_b[c*W +: W] = h[31:0];
            end else begin
                in_valid_b[c] = 1'b0; in_last_b[c] = 1'b0; in_data_b[c*W +: W] = '0;
            end
        end
        fire_a = '0;
        fire_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) qa[c].push_back({1'b1, 32'hA0 + 32'(c)});
        drive_all();

        // Reset held for two edges with every channel valid
        tick();
        mon_on = 1'b1;
        sample();
        chk("a.reset.in_ready", 64'(in_ready_a), 64'h0);
        chk("a.reset.out_valid", 64'(out_valid_a), 64'h0);
        chk("a.reset.out_data", 64'(out_data_a), 64'h0);
        chk("a.reset.out_ch", 64'(out_ch_a), 64'h0);
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        sample();
        chk("a.post_reset.in_ready", 64'(in_ready_a), 64'h1);
        chk("a.post_reset.out_valid", 64'(out_valid_a), 64'h0);

        // Round-robin over single-beat packets, including the ch3 -> ch0 wrap
        run(9);
        sample();
        chk("a.rr.count", 64'(loga.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("a.rr.beat%0d", i), 64'(log_at(0, i)), 64'(bt(1'b1, i % 4, 32'hA0 + 32'(i % 4))));
        loga.delete();

        // ch1 three-beat packet must not be interleaved by ch0/ch2
        qa[0].push_back({1'b1, 32'hB0}); qa[0].push_back({1'b1, 32'hB1});
        qa[1].push_back({1'b0, 32'h11}); qa[1].push_back({1'b0, 32'h12});
        qa[1].push_back({1'b1, 32'h13});
        qa[2].push_back({1'b1, 32'h22});
        run(10);
        sample();
        chk("a.lock.count", 64'(loga.size()), 64'd6);
        chk("a.lock.beat0", 64'(log_at(0, 0)), 64'(bt(1'b1, 0, 32'hB0)));
        chk("a.lock.beat1", 64'(log_at(0, 1)), 64'(bt(1'b0, 1, 32'h11)));
        chk("a.lock.beat2", 64'(log_at(0, 2)), 64'(bt(1'b0, 1, 32'h12)));
        chk("a.lock.beat3", 64'(log_at(0, 3)), 64'(bt(1'b1, 1, 32'h13)));
        chk("a.lock.next_ch2", 64'(log_at(0, 4)), 64'(bt(1'b1, 2, 32'h22)));
        chk("a.lock.beat5", 64'(log_at(0, 5)), 64'(bt(1'b1, 0, 32'hB1)));
        loga.delete();

        // Three-cycle stall in the middle of a ch3 packet
        qa[3].push_back({1'b0, 32'h31}); qa[3].push_back({1'b0, 32'h32});
        qa[3].push_back({1'b0, 32'h33}); qa[3].push_back({1'b1, 32'h34});
        run(3);
        out_ready_a = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sample();
            chk($sformatf("a.stall%0d.out_data", s), 64'(out_data_a), 64'h32);
            chk($sformatf("a.stall%0d.out_ch", s), 64'(out_ch_a), 64'd3);
            chk($sformatf("a.stall%0d.out_last", s), 64'(out_last_a), 64'd0);
            chk($sformatf("a.stall%0d.in_ready", s), 64'(in_ready_a), 64'h0);
            tick();
        end
        out_ready_a = 1'b1;
        run(6);
        sample();
        chk("a.bp.count", 64'(loga.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("a.bp.beat%0d", i), 64'(log_at(0, i)), 64'(bt(i == 3, 3, 32'h31 + 32'(i))));
        loga.delete();

        // Reset after the first beat of a ch2 packet discards the lock
        qa[2].push_back({1'b0, 32'h41}); qa[2].push_back({1'b0, 32'h42});
        qa[2].push_back({1'b0, 32'h43}); qa[2].push_back({1'b1, 32'h44});
        run(2);
        rst_a = 1'b1;
        tick();
        sample();
        chk("a.midrst.out_valid", 64'(out_valid_a), 64'h0);
        chk("a.midrst.in_ready", 64'(in_ready_a), 64'h0);
        qa[2].delete();
        qa[0].push_back({1'b1, 32'h50});
        tick();
        rst_a = 1'b0;
        run(3);
        sample();
        chk("a.midrst.count", 64'(loga.size()), 64'd2);
        chk("a.midrst.beat0", 64'(log_at(0, 0)), 64'(bt(1'b0, 2, 32'h41)));
        chk("a.midrst.after", 64'(log_at(0, 1)), 64'(bt(1'b1, 0, 32'h50)));

        // Fixed priority: ch0 drains completely before ch3 is served
        for (int i = 0; i < 4; i++) qb[0].push_back({1'b1, 32'hC0 + 32'(i)});
        qb[3].push_back({1'b1, 32'hD0}); qb[3].push_back({1'b1, 32'hD1});
        run(9);
        sample();
        chk("b.prio.count", 64'(logb.size()), 64'd6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b.prio.beat%0d", i), 64'(log_at(1, i)), 64'(bt(1'b1, 0, 32'hC0 + 32'(i))));
        chk("b.prio.beat4", 64'(log_at(1, 4)), 64'(bt(1'b1, 3, 32'hD0)));
        chk("b.prio.beat5", 64'(log_at(1, 5)), 64'(bt(1'b1, 3, 32'hD1)));
        logb.delete();

        // Lock beats priority: ch0 arriving mid-packet waits for ch3's last beat
        qb[3].push_back({1'b0, 32'hE0}); qb[3].push_back({1'b1, 32'hE1});
        tick();
        qb[0].push_back({1'b1, 32'hF0});
        tick();
        sample();
        chk("b.lock.in_ready", 64'(in_ready_b), 64'h8);
        run(5);
        sample();
        chk("b.lock.count", 64'(logb.size()), 64'd3);
        chk("b.lock.beat0", 64'(log_at(1, 0)), 64'(bt(1'b0, 3, 32'hE0)));
        chk("b.lock.beat1", 64'(log_at(1, 1)), 64'(bt(1'b1, 3, 32'hE1)));
        chk("b.lock.beat2", 64'(log_at(1, 2)), 64'(bt(1'b1, 0, 32'hF0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
